// File: rtl/eeprom_cmd_pkg.sv
// Shared definitions for the M25AA010A command sequencer: opcodes, the
// status-register WIP bit position and the sequencer state encoding.
// Build option: EEPROM_VERIFY_EN adds read-back verify states.
package eeprom_cmd_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    // Write-in-progress flag inside the RDSR status byte
    localparam int WIP_BIT = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_WR_CMD,
        S_WR_ADDR,
        S_WR_DATA,
        S_POLL_CMD,
        S_POLL_RD,
        S_RD_CMD,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
`ifdef EEPROM_VERIFY_EN
        ,
        S_VF_CMD,
        S_VF_ADDR,
        S_VF_DATA
`endif
    } state_t;

    // First byte sent when a gap ends and the next frame opens
    function automatic logic [7:0] gap_exit_opcode(input state_t s);
        case (s)
            S_WR_CMD:   return OP_WRITE;
            S_POLL_CMD: return OP_RDSR;
            default:    return OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_gap_timer.sv
// Chip-select deselect timer. Held loaded while i_start is high; once
// released it counts down and o_done is high in the GAP_CYC-th cycle.
module eeprom_gap_timer #(
    parameter int GAP_CYC = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    output logic o_done
);

    localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [CW-1:0] r_cnt;

    // Reload while idle, count down to zero while the gap runs
    always_ff @(posedge i_clk) begin
        if (i_reset || i_start) begin
            r_cnt <= CW'(GAP_CYC - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/eeprom_cmd_seq.sv
// Command sequencer in front of the SPI byte engine for an M25AA010A.
// Expands single-byte read/write requests into WREN / WRITE / RDSR-poll or
// READ frames and returns a one-cycle response.
// Build option: EEPROM_VERIFY_EN reads the byte back after a good write.
//
// Handshake: a request transfers on the clock edge where req_valid and
// req_ready are both high; req_ready is high only while idle, and
// req_valid at any other time is ignored. Responses are a single-cycle
// rsp_valid with no back-pressure; rsp_rdata/rsp_err hold until the next one.
module eeprom_cmd_seq
    import eeprom_cmd_pkg::*;
#(
    parameter int POLL_MAX = 16,
    parameter int GAP_CYC  = 8
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       write,
    output logic [7:0] write_value,
    input  logic       write_complete,
    output logic       read,
    input  logic [7:0] read_value,
    input  logic       read_complete,
    output logic       spi_frame,
    output state_t     dbg_state
);

    state_t      r_state;
    state_t      r_gap_next;
    logic [6:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [15:0] r_poll_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_wr_pulse;
    logic        r_rd_pulse;
    logic [7:0]  r_wr_value;
    logic        r_frame;

    logic        w_gap_start;
    logic        w_gap_done;

    assign w_gap_start = (r_state != S_GAP);

    eeprom_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .i_clk   (clk_50M),
        .i_reset (reset),
        .i_start (w_gap_start),
        .o_done  (w_gap_done)
    );

    // Sequencer: each byte state opens with a one-cycle write/read pulse
    // issued on entry and advances on the matching complete pulse.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap_next  <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_poll_cnt  <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wr_pulse  <= 1'b0;
            r_rd_pulse  <= 1'b0;
            r_wr_value  <= '0;
            r_frame     <= 1'b0;
        end else begin
            r_wr_pulse  <= 1'b0;
            r_rd_pulse  <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_poll_cnt  <= '0;
                        r_req_ready <= 1'b0;
                        r_frame     <= 1'b1;
                        r_wr_pulse  <= 1'b1;
                        if (req_write) begin
                            r_wr_value <= OP_WREN;
                            r_state    <= S_WREN;
                        end else begin
                            r_wr_value <= OP_READ;
                            r_state    <= S_RD_CMD;
                        end
                    end
                end
                S_WREN: begin
                    if (write_complete) begin
                        r_frame    <= 1'b0;
                        r_gap_next <= S_WR_CMD;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_frame    <= 1'b1;
                        r_wr_pulse <= 1'b1;
                        r_wr_value <= gap_exit_opcode(r_gap_next);
                        r_state    <= r_gap_next;
                        if (r_gap_next == S_POLL_CMD && r_poll_cnt != 16'hFFFF) begin
                            r_poll_cnt <= r_poll_cnt + 16'd1;
                        end
                    end
                end
                S_WR_CMD: begin
                    if (write_complete) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_value <= {1'b0, r_addr};
                        r_state    <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    if (write_complete) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_value <= r_wdata;
                        r_state    <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (write_complete) begin
                        r_frame    <= 1'b0;
                        r_gap_next <= S_POLL_CMD;
                        r_state    <= S_GAP;
                    end
                end
                S_POLL_CMD: begin
                    if (write_complete) begin
                        r_rd_pulse <= 1'b1;
                        r_state    <= S_POLL_RD;
                    end
                end
                S_POLL_RD: begin
                    if (read_complete) begin
                        r_frame <= 1'b0;
                        if (!read_value[WIP_BIT]) begin
`ifdef EEPROM_VERIFY_EN
                            r_gap_next <= S_VF_CMD;
                            r_state    <= S_GAP;
`else
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 8'h00;
                            r_rsp_err   <= 1'b0;
                            r_state     <= S_DONE;
`endif
                        end else if (r_poll_cnt >= 16'(POLL_MAX)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 8'h00;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_gap_next <= S_POLL_CMD;
                            r_state    <= S_GAP;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (write_complete) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_value <= {1'b0, r_addr};
                        r_state    <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (write_complete) begin
                        r_rd_pulse <= 1'b1;
                        r_state    <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (read_complete) begin
                        r_frame     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= read_value;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
`ifdef EEPROM_VERIFY_EN
                S_VF_CMD: begin
                    if (write_complete) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_value <= {1'b0, r_addr};
                        r_state    <= S_VF_ADDR;
                    end
                end
                S_VF_ADDR: begin
                    if (write_complete) begin
                        r_rd_pulse <= 1'b1;
                        r_state    <= S_VF_DATA;
                    end
                end
                S_VF_DATA: begin
                    if (read_complete) begin
                        r_frame     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= read_value;
                        r_rsp_err   <= (read_value != r_wdata);
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_frame     <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign write       = r_wr_pulse;
    assign write_value = r_wr_value;
    assign read        = r_rd_pulse;
    assign spi_frame   = r_frame;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Bench for eeprom_cmd_seq: byte-engine + EEPROM model, byte-stream and
// response scoreboards, directed scenarios followed by random requests.
`timescale 1ns/1ps
module tb_eeprom_cmd_seq;
    import eeprom_cmd_pkg::*;

    localparam int TB_POLL_MAX = 4;
    localparam int TB_GAP      = 8;

    // ---------------- clock / reset ----------------
    logic       clk_50M = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       write_complete = 1'b0;
    logic       read_complete = 1'b0;
    logic [7:0] read_value = '0;
    logic       req_ready, rsp_valid, rsp_err, write, read, spi_frame;
    logic [7:0] rsp_rdata, write_value;
    state_t     dbg_state;

    always #10 clk_50M = ~clk_50M;

    eeprom_cmd_seq #(
        .POLL_MAX (TB_POLL_MAX),
        .GAP_CYC  (TB_GAP)
    ) dut (
        .clk_50M        (clk_50M),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .write          (write),
        .write_value    (write_value),
        .write_complete (write_complete),
        .read           (read),
        .read_value     (read_value),
        .read_complete  (read_complete),
        .spi_frame      (spi_frame),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];       // {err, rdata} per request
    logic [8:0] exp_byte_q[$];  // {is_read, byte} per byte-engine pulse
    logic [7:0] dev_mem[128];
    logic [7:0] ref_mem[128];
    logic [7:0] fb[$];          // bytes of the frame currently open
    int         dev_busy = 0;
    int         dev_busy_next = 0;
    bit         dev_corrupt = 0;
    bit         inject_spurious = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic byte_check(input logic is_rd, input logic [7:0] b);
        logic [8:0] e;
        if (exp_byte_q.size() == 0) begin
            fail_now($sformatf("unexpected_byte rd=%0d val=0x%0h", is_rd, b));
        end else begin
            e = exp_byte_q.pop_front();
            check("spi_byte", {is_rd, b}, e);
        end
    endtask

    // EEPROM reaction to a completed frame
    task automatic frame_end();
        if (fb.size() == 3 && fb[0] == OP_WRITE) begin
            dev_mem[fb[1][6:0]] = dev_corrupt ? 8'h00 : fb[2];
            dev_busy = dev_busy_next;
            dev_corrupt = 0;
        end
        fb.delete();
    endtask

    function automatic logic [7:0] dev_read();
        logic [7:0] v;
        v = 8'hEE;
        if (fb.size() >= 1 && fb[0] == OP_RDSR) begin
            v = {7'($urandom), (dev_busy > 0) ? 1'b1 : 1'b0};
            if (dev_busy > 0) dev_busy--;
        end else if (fb.size() >= 2 && fb[0] == OP_READ) begin
            v = dev_mem[fb[1][6:0]];
        end
        return v;
    endfunction

    // ---------------- byte engine + device + byte monitor ----------------
    initial begin : engine
        bit         wpend, rpend, fprev, in_gap;
        int         wlat, rlat, low_cnt;
        logic [7:0] rbyte;
        wpend = 0; rpend = 0; fprev = 0; in_gap = 0;
        wlat = 0; rlat = 0; low_cnt = 0; rbyte = '0;
        forever begin
            @(negedge clk_50M);
            write_complete = 1'b0;
            read_complete  = 1'b0;
            if (reset) begin
                wpend = 0; rpend = 0; in_gap = 0; fprev = 0;
                fb.delete();
            end else begin
                if (fprev && !spi_frame) begin
                    frame_end();
                    if (!rsp_valid) begin
                        in_gap = 1;
                        low_cnt = 0;
                    end
                end
                if (!spi_frame && in_gap) low_cnt++;
                if (!fprev && spi_frame && in_gap) begin
                    check("gap_len", low_cnt, TB_GAP);
                    in_gap = 0;
                end
                fprev = spi_frame;

                if (write) begin
                    fb.push_back(write_value);
                    byte_check(1'b0, write_value);
                    wpend = 1;
                    wlat = $urandom_range(0, 3);
                end
                if (read) begin
                    byte_check(1'b1, 8'h00);
                    rbyte = dev_read();
                    rpend = 1;
                    rlat = $urandom_range(0, 3);
                end
                if (wpend) begin
                    if (wlat == 0) begin
                        write_complete = 1'b1;
                        wpend = 0;
                    end else begin
                        wlat--;
                    end
                end else if (inject_spurious && dbg_state == S_GAP) begin
                    write_complete = 1'b1;
                    inject_spurious = 0;
                end
                if (rpend) begin
                    if (rlat == 0) begin
                        read_value = rbyte;
                        read_complete = 1'b1;
                        rpend = 0;
                    end else begin
                        rlat--;
                    end
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : rsp_monitor
        logic [8:0] e;
        forever begin
            @(negedge clk_50M);
            if (!reset && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_rsp err=%0d rdata=0x%0h", rsp_err, rsp_rdata));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {rsp_err, rsp_rdata}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
        if (!req_ready) fail_now("req_ready_timeout");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
        if (exp_q.size() != 0) fail_now("response_timeout");
        @(negedge clk_50M);
    endtask

    // Reference model: whole expected byte stream and response per request
    task automatic issue(input bit wr, input logic [6:0] a, input logic [7:0] d,
                         input int busy, input bit corrupt);
        int         polls;
        bit         ok;
        logic [7:0] stored;
        wait_ready();
        if (wr) begin
            ok = (busy < TB_POLL_MAX);
            polls = ok ? busy + 1 : TB_POLL_MAX;
            stored = corrupt ? 8'h00 : d;
            exp_byte_q.push_back({1'b0, OP_WREN});
            exp_byte_q.push_back({1'b0, OP_WRITE});
            exp_byte_q.push_back({2'b00, a});
            exp_byte_q.push_back({1'b0, d});
            for (int i = 0; i < polls; i++) begin
                exp_byte_q.push_back({1'b0, OP_RDSR});
                exp_byte_q.push_back(9'h100);
            end
`ifdef EEPROM_VERIFY_EN
            if (ok) begin
                exp_byte_q.push_back({1'b0, OP_READ});
                exp_byte_q.push_back({2'b00, a});
                exp_byte_q.push_back(9'h100);
                exp_q.push_back({stored != d, stored});
            end else begin
                exp_q.push_back({1'b1, 8'h00});
            end
`else
            exp_q.push_back({!ok, 8'h00});
`endif
            ref_mem[a] = stored;
            dev_busy_next = busy;
            dev_corrupt = corrupt;
        end else begin
            exp_byte_q.push_back({1'b0, OP_READ});
            exp_byte_q.push_back({2'b00, a});
            exp_byte_q.push_back(9'h100);
            exp_q.push_back({1'b0, ref_mem[a]});
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk_50M);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 7'($urandom);
        req_wdata = 8'($urandom);
        check("req_ready_drop", req_ready, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, write, 1'b0);
        check({tag, "_read"}, read, 1'b0);
        check({tag, "_frame"}, spi_frame, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
        check({tag, "_write_value"}, write_value, 8'h00);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] saved;
        int         n;
        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk_50M);

        // single write, device ready at first poll
        issue(1'b1, 7'h00, 8'h78, 0, 1'b0);
        wait_done();
        check("mem00", dev_mem[0], 8'h78);

        // write then read back with a few busy polls
        issue(1'b1, 7'h01, 8'h9A, 2, 1'b0);
        issue(1'b0, 7'h01, 8'h00, 0, 1'b0);
        wait_done();

        // device stuck busy: exactly POLL_MAX polls then error
        issue(1'b1, 7'h03, 8'h11, 20, 1'b0);
        wait_done();
        // poll on the last allowed attempt succeeds
        issue(1'b1, 7'h04, 8'h22, TB_POLL_MAX - 1, 1'b0);
        wait_done();

        // reset in the middle of the write frame
        saved = ref_mem[2];
        issue(1'b1, 7'h02, 8'h44, 0, 1'b0);
        n = 0;
        while (dbg_state != S_WR_ADDR && n < 500) begin
            @(negedge clk_50M);
            n++;
        end
        if (dbg_state != S_WR_ADDR) fail_now("wr_addr_not_reached");
        reset = 1'b1;
        @(negedge clk_50M);
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_byte_q.delete();
        ref_mem[2] = saved;
        dev_corrupt = 0;
        reset = 1'b0;
        @(negedge clk_50M);
        issue(1'b1, 7'h02, 8'hBC, 1, 1'b0);
        issue(1'b0, 7'h02, 8'h00, 0, 1'b0);
        wait_done();

        // request while busy is ignored; stray complete during a gap
        inject_spurious = 1;
        issue(1'b1, 7'h10, 8'h3C, 1, 1'b0);
        repeat (2) @(negedge clk_50M);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 7'h05;
        repeat (3) @(negedge clk_50M);
        req_valid = 1'b0;
        wait_done();

        // stored byte corrupted by the device
        issue(1'b1, 7'h7F, 8'h55, 0, 1'b1);
        wait_done();
        issue(1'b0, 7'h7F, 8'h00, 0, 1'b0);
        wait_done();

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                  $urandom_range(0, TB_POLL_MAX + 1), 1'($urandom_range(0, 7) == 0));
        end
        wait_done();
        repeat (TB_GAP + 4) @(negedge clk_50M);

        check("bytes_left", exp_byte_q.size(), 0);
        check("rsp_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_cmd_seq.md
Name: eeprom_cmd_seq

Overview:
Command sequencer that sits directly upstream of the SPI byte engine (write/read byte handshake) driving an M25AA010A 128-byte EEPROM.
- Accepts single-byte read/write requests.
- Expands each request into the device byte sequence: WREN, then WRITE, then RDSR polling; or READ.
- Replaces fixed software delays with status polling, and reports completion or error on a one-cycle response.

Parameters:
POLL_MAX, 16, maximum RDSR polls per write before timeout error (range 1..65535).
GAP_CYC, 8, clk_50M cycles spi_frame is held low between frames (CS deselect time).

Ports:
clk_50M  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted on req_valid&&req_ready
req_write  input  1  1 = write byte, 0 = read byte
req_addr  input  7  EEPROM byte address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  8  read data; valid with rsp_valid
rsp_err  output  1  poll timeout (or verify mismatch); valid with rsp_valid
write  output  1  one-cycle pulse to byte engine: send write_value
write_value  output  8  byte to send; stable from pulse until write_complete
write_complete  input  1  byte engine finished a send (one-cycle pulse)
read  output  1  one-cycle pulse: clock in one byte
read_value  input  8  received byte; valid with read_complete
read_complete  input  1  byte engine finished a receive (one-cycle pulse)
spi_frame  output  1  high across all bytes of one frame; byte engine holds CSn low while high

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs are 0 except req_ready=1. Poll counter is 0. Applies on the next edge even mid-frame; the in-flight byte is abandoned (the byte engine shares the reset).
- Opcodes: WREN 0x06, WRITE 0x02, READ 0x03, RDSR 0x05. Address byte = {1'b0, req_addr}.
- Request capture: on acceptance, latch write/addr/wdata; req_ready drops the next cycle. req_valid while busy is ignored.
- Byte step:
  - spi_frame is raised first.
  - In the same cycle, pulse write (or read) for one cycle.
  - Wait in the state for write_complete (or read_complete). Completes arriving in a state not waiting for them are ignored.
  - Advance on the complete cycle.
- Write path states: IDLE -> WREN -> GAP -> WR_CMD -> WR_ADDR -> WR_DATA -> GAP -> POLL_CMD -> POLL_RD -> (GAP -> POLL_CMD ... | DONE).
  - Frames: [06], [02 addr data], [05 status]. spi_frame is low for exactly GAP_CYC cycles between frames.
  - POLL_RD checks status bit0 (WIP).
    - WIP=0 -> DONE with err=0.
    - WIP=1 and polls < POLL_MAX -> GAP, repoll.
    - WIP=1 on poll number POLL_MAX -> DONE with err=1.
- Read path: IDLE -> RD_CMD -> RD_ADDR -> RD_DATA -> DONE. Frame [03 addr] followed by one read; rsp_rdata = read_value captured on read_complete.
- DONE: spi_frame=0; rsp_valid=1 for one cycle, the cycle after the final complete; return to IDLE the next cycle.
- rsp_rdata = 0 for writes (unless the verify feature is on). rsp_rdata/rsp_err hold their values until the next rsp_valid.
- The poll counter is 16 bits and saturates; it clears at request acceptance.

Optional Feature:
EEPROM_VERIFY_EN
- Defined: after a successful poll on a write, run a read frame [03 addr] + read.
  - rsp_rdata = read-back byte.
  - rsp_err=1 if read-back != latched wdata.
  - On poll timeout, skip verify.
- Undefined: no verify states exist; write response is as above.

Decomposition:
- Package eeprom_cmd_pkg holds:
  - opcode constants (OP_WREN, OP_WRITE, OP_READ, OP_RDSR);
  - WIP bit index;
  - state enum typedef.
- Sub-module eeprom_gap_timer: GAP_CYC down-counter with start/done, reused between frames.

Test Plan:
1. Write addr 0x00 data 0x78; model status 0x00 -> bytes 06 | 02 00 78 | 05; one RDSR; rsp_valid with err=0, rdata=0x00; EEPROM byte00 = 0x78.
2. Write 0x01/0x9A, then read 0x01 -> read frame 03 01; rsp_rdata=0x9A, err=0.
3. POLL_MAX=4, model status stuck at 0x01 -> exactly 4 RDSR frames, each separated by GAP_CYC low cycles; rsp_err=1.
4. Assert reset while in WR_ADDR -> next cycle write=read=spi_frame=rsp_valid=0, req_ready=1; a new write 0x02/0xBC then completes normally.
5. Pulse req_valid with addr 0x05 during an active write -> not accepted; only the original request gets rsp_valid; spurious write_complete injected in GAP is ignored.
6. EEPROM_VERIFY_EN defined, model corrupts stored byte to 0x00 on write 0x7F/0x55 -> rsp_rdata=0x00, rsp_err=1.
